// File: rtl/serial_rx_if.sv
// serial_rx_if -- bundle of the UART receive line and the byte-level outputs.
//   rx           : asynchronous UART line (idle high, 8N1, LSB first)
//   rxReady      : one-cycle pulse, new byte on rxData
//   rxData       : last correctly received byte
//   rxFrameError : one-cycle pulse, stop bit sampled low
//   rxBusy       : high while a frame is in progress
// master = the receiver (drives the outputs), slave = line driver / consumer.
interface serial_rx_if;
  logic       rx;
  logic       rxReady;
  logic [7:0] rxData;
  logic       rxFrameError;
  logic       rxBusy;

  modport master (
    input  rx,
    output rxReady, rxData, rxFrameError, rxBusy
  );

  modport slave (
    output rx,
    input  rxReady, rxData, rxFrameError, rxBusy
  );
endinterface

// File: rtl/serial_rx.sv
// serial_rx -- UART 8N1 receiver with start-bit glitch rejection and
// break handling.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : serial_rx_if.master (rx in; rxReady/rxData/rxFrameError/rxBusy out)
// Parameter:
//   CLKS_PER_BIT : clk cycles per UART bit (8..65535)
module serial_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  serial_rx_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAKWAIT
  } state_t;

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  logic        r_meta;
  logic        r_rs;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_ready;
  logic        r_ferr;
  logic        r_busy;

  logic        w_half_done;
  logic        w_bit_done;

  assign w_half_done = (r_cnt == HALF_LAST);
  assign w_bit_done  = (r_cnt == BIT_LAST);

  // Synchronizer stage: both flops come out of reset high (line idle).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_rs   <= 1'b1;
    end else begin
      r_meta <= bus.rx;
      r_rs   <= r_meta;
    end
  end

  // Frame state machine; the baud counter restarts from 0 at every sample
  // point so timing error never accumulates across bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_ready  <= 1'b0;
      r_ferr   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_rs) begin
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_state  <= START;
            r_busy   <= 1'b1;
          end
        end
        START: begin
          if (w_half_done) begin
            r_cnt <= '0;
            if (!r_rs) begin
              r_bitcnt <= '0;
              r_state  <= DATA;
            end else begin
              // Start bit vanished before its mid-point: treat as a glitch.
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DATA: begin
          if (w_bit_done) begin
            r_cnt    <= '0;
            r_shift  <= {r_rs, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_state <= STOP;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        STOP: begin
          if (w_bit_done) begin
            r_cnt <= '0;
            if (r_rs) begin
              r_data  <= r_shift;
              r_ready <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= BREAKWAIT;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        BREAKWAIT: begin
          // Hold here through a break so it yields a single frame error.
          if (r_rs) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rxReady      = r_ready;
  assign bus.rxData       = r_data;
  assign bus.rxFrameError = r_ferr;
  assign bus.rxBusy       = r_busy;

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx -- scoreboard bench for serial_rx. Instance 0 runs with
// CLKS_PER_BIT=16, instance 1 with CLKS_PER_BIT=434 for baud-offset tests.
module tb_serial_rx;

  logic clk;
  logic reset;
  logic [1:0] rx_line;

  serial_rx_if bus_a ();
  serial_rx_if bus_b ();

  assign bus_a.rx = rx_line[0];
  assign bus_b.rx = rx_line[1];

  serial_rx #(.CLKS_PER_BIT(16))  u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  serial_rx #(.CLKS_PER_BIT(434)) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         inst;
    bit         fe;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] model_data [2];
  logic [1:0] prev_pulse;

  logic [1:0] rdy, fe, busy;
  logic [7:0] dat [2];

  assign rdy  = {bus_b.rxReady, bus_a.rxReady};
  assign fe   = {bus_b.rxFrameError, bus_a.rxFrameError};
  assign busy = {bus_b.rxBusy, bus_a.rxBusy};
  assign dat[0] = bus_a.rxData;
  assign dat[1] = bus_b.rxData;

  // Monitor: pops the scoreboard whenever either receiver emits a pulse.
  initial prev_pulse = 2'b00;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rdy[i] || fe[i]) begin
        n_vec++;
        if (rdy[i] && fe[i]) begin
          n_err++;
          $display("FAIL both_pulses inst%0d: rxReady and rxFrameError high together", i);
        end else if (prev_pulse[i]) begin
          n_err++;
          $display("FAIL pulse_width inst%0d: pulse longer than one cycle, required 1", i);
        end else if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected inst%0d: got rdy=%0b fe=%0b data=%02h, required no pulse",
                   i, rdy[i], fe[i], dat[i]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.inst != i || e.fe != fe[i]) begin
            n_err++;
            $display("FAIL pulse_kind inst%0d: got fe=%0b, required inst%0d fe=%0b",
                     i, fe[i], e.inst, e.fe);
          end else if (rdy[i] && dat[i] !== e.data) begin
            n_err++;
            $display("FAIL rx_byte inst%0d: got %02h, required %02h", i, dat[i], e.data);
          end else if (fe[i] && dat[i] !== model_data[i]) begin
            n_err++;
            $display("FAIL ferr_data inst%0d: got %02h, required unchanged %02h",
                     i, dat[i], model_data[i]);
          end
          if (!e.fe) model_data[e.inst] = e.data;
        end
      end
      prev_pulse[i] = rdy[i] | fe[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int inst, input logic v, input int per);
    rx_line[inst] = v;
    repeat (per) @(negedge clk);
  endtask

  task automatic send(input int inst, input logic [7:0] b, input int per, input bit stop_ok);
    exp_t e;
    e.inst = inst;
    e.fe   = !stop_ok;
    e.data = b;
    exp_q.push_back(e);
    drive_bit(inst, 1'b0, per);
    for (int k = 0; k < 8; k++) drive_bit(inst, b[k], per);
    drive_bit(inst, stop_ok, per);
  endtask

  task automatic drain(input string name, input int limit);
    for (int k = 0; k < limit; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_line = 2'b11;
    model_data[0] = 8'h00;
    model_data[1] = 8'h00;
    reset = 1'b1;
    idle(4);
    reset = 1'b0;
    idle(1);

    chk("reset_rxData_a", bus_a.rxData, 8'h00);
    chk("reset_rxReady_a", bus_a.rxReady, 1'b0);
    chk("reset_rxFrameError_a", bus_a.rxFrameError, 1'b0);
    chk("reset_rxBusy_a", bus_a.rxBusy, 1'b0);
    chk("reset_rxBusy_b", bus_b.rxBusy, 1'b0);

    // Single byte
    send(0, 8'hA5, 16, 1'b1);
    idle(20);
    drain("drain_a5", 200);
    chk("busy_after_a5", busy[0], 1'b0);

    // Back-to-back frames, no idle gap
    send(0, 8'h00, 16, 1'b1);
    send(0, 8'hFF, 16, 1'b1);
    send(0, 8'h0B, 16, 1'b1);
    idle(20);
    drain("drain_b2b", 200);

    // Short low glitch on the line
    rx_line[0] = 1'b0;
    idle(5);
    rx_line[0] = 1'b1;
    idle(30);
    chk("busy_after_glitch", busy[0], 1'b0);
    chk("queue_after_glitch", exp_q.size(), 0);

    // Stop bit low followed by a break
    send(0, 8'h3C, 16, 1'b0);
    rx_line[0] = 1'b0;
    idle(50);
    chk("busy_in_break", busy[0], 1'b1);
    idle(50);
    rx_line[0] = 1'b1;
    idle(20);
    chk("busy_after_break", busy[0], 1'b0);
    drain("drain_ferr", 50);
    send(0, 8'h5A, 16, 1'b1);
    idle(20);
    drain("drain_5a", 200);

    // Reset in the middle of data bit 4 of 8'h81
    drive_bit(0, 1'b0, 16);
    for (int k = 0; k < 4; k++) drive_bit(0, k == 0, 16);
    drive_bit(0, 1'b0, 8);
    reset = 1'b1;
    rx_line[0] = 1'b1;
    idle(3);
    reset = 1'b0;
    model_data[0] = 8'h00;
    model_data[1] = 8'h00;
    idle(20);
    chk("rxData_after_midreset", bus_a.rxData, 8'h00);
    chk("busy_after_midreset", busy[0], 1'b0);
    send(0, 8'h11, 16, 1'b1);
    idle(20);
    drain("drain_11", 200);

    // Baud offset +2% and -2% at CLKS_PER_BIT=434
    send(1, 8'h55, 425, 1'b1);
    idle(200);
    drain("drain_55_fast", 2000);
    send(1, 8'h55, 443, 1'b1);
    idle(200);
    drain("drain_55_slow", 2000);
    chk("rxData_b_final", bus_b.rxData, 8'h55);
    chk("busy_b_final", busy[1], 1'b0);

    idle(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
